// File: rtl/arbitro_rr_param.sv
// Parametrised round-robin / strict-priority arbiter draining NUM_CH show-ahead
// input FIFOs into 2**DEST_W output FIFOs, skipping channels whose target is almost full.
module arbitro_rr_param #(
    parameter int NUM_CH = 4,
    parameter int DEST_W = 2,
    parameter int DATA_W = 6,
    parameter int CNT_W  = 8,
    localparam int NOUT  = 2**DEST_W,
    localparam int ID_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic                     enable,
    input  logic                     rr_mode,
    input  logic [NUM_CH-1:0]        empty,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    input  logic [NOUT-1:0]          almost_full,
    output logic [NUM_CH-1:0]        pop,
    output logic [NOUT-1:0]          push,
    output logic [DATA_W-1:0]        data_out,
    output logic [ID_W-1:0]          grant_id,
    output logic [CNT_W-1:0]         fwd_count,
    output logic                     idle
);

    logic [DATA_W-1:0] head [NUM_CH];
    logic [NUM_CH-1:0] eligible;
    logic [ID_W-1:0]   last;
    logic              found;
    logic [ID_W-1:0]   win;
    logic [DATA_W-1:0] win_word;
    logic [DEST_W-1:0] win_dest;
    logic [NOUT-1:0]   push_next;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_head
        assign head[g] = data_in[g*DATA_W +: DATA_W];
    end

    assign idle = &empty;

    // A channel is only eligible if its own destination can take the word, so a
    // full output never blocks channels heading elsewhere.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            eligible[i] = enable & ~empty[i] & ~almost_full[head[i][DATA_W-1 -: DEST_W]];
        end
    end

    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        if (rr_mode) begin
            for (int k = 1; k <= NUM_CH; k++) begin
                idx = int'(last) + k;
                if (idx >= NUM_CH) begin
                    idx = idx - NUM_CH;
                end
                if (!found && eligible[ID_W'(idx)]) begin
                    found = 1'b1;
                    win   = ID_W'(idx);
                end
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!found && eligible[i]) begin
                    found = 1'b1;
                    win   = ID_W'(i);
                end
            end
        end
    end

    always_comb begin
        win_word = '0;
        pop      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (found && (win == ID_W'(i))) begin
                win_word = head[i];
                pop[i]   = 1'b1;
            end
        end
    end

    assign win_dest = win_word[DATA_W-1 -: DEST_W];

    always_comb begin
        push_next = '0;
        for (int o = 0; o < NOUT; o++) begin
            push_next[o] = found && (win_dest == DEST_W'(o));
        end
    end

    // last resets to the top channel so channel 0 is first in round-robin order.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            push      <= '0;
            data_out  <= '0;
            grant_id  <= '0;
            fwd_count <= '0;
            last      <= ID_W'(NUM_CH - 1);
        end else begin
            push <= push_next;
            if (found) begin
                data_out  <= win_word;
                grant_id  <= win;
                fwd_count <= fwd_count + CNT_W'(1);
                last      <= win;
            end
        end
    end

endmodule

// File: tb/tb_arbitro_rr_param.sv
// Bench for arbitro_rr_param: directed scenarios plus random traffic, all checked
// against a distance-based arbitration model held in the bench.
module tb_arbitro_rr_param;

    localparam int NUM_CH = 4;
    localparam int DEST_W = 2;
    localparam int DATA_W = 6;
    localparam int CNT_W  = 8;
    localparam int NOUT   = 4;

    logic                     clk = 1'b0;
    logic                     reset_L;
    logic                     enable;
    logic                     rr_mode;
    logic [NUM_CH-1:0]        empty;
    logic [NUM_CH*DATA_W-1:0] data_in;
    logic [NOUT-1:0]          almost_full;
    logic [NUM_CH-1:0]        pop;
    logic [NOUT-1:0]          push;
    logic [DATA_W-1:0]        data_out;
    logic [1:0]               grant_id;
    logic [CNT_W-1:0]         fwd_count;
    logic                     idle;

    int checks   = 0;
    int failures = 0;
    int hd [NUM_CH];
    int m_last, m_push, m_data, m_gid, m_cnt;
    int pop_s;

    arbitro_rr_param #(
        .NUM_CH(NUM_CH), .DEST_W(DEST_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_L(reset_L), .enable(enable), .rr_mode(rr_mode),
        .empty(empty), .data_in(data_in), .almost_full(almost_full),
        .pop(pop), .push(push), .data_out(data_out), .grant_id(grant_id),
        .fwd_count(fwd_count), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_push = 0; m_data = 0; m_gid = 0; m_cnt = 0; m_last = NUM_CH - 1;
    endtask

    // Winner = eligible channel with the smallest distance after last (rr) or smallest index.
    function automatic int model_win();
        int e, a, d, best, bestd;
        best = -1; bestd = 1000;
        if (!enable) return -1;
        e = int'(empty);
        a = int'(almost_full);
        for (int i = 0; i < NUM_CH; i++) begin
            if (((e >> i) & 1) == 0 && ((a >> ((hd[i] >> 4) & 3)) & 1) == 0) begin
                d = rr_mode ? (i - m_last - 1 + 2*NUM_CH) % NUM_CH : i;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    task automatic drive_heads();
        data_in = {6'(hd[3]), 6'(hd[2]), 6'(hd[1]), 6'(hd[0])};
    endtask

    task automatic set_heads(input int h0, input int h1, input int h2, input int h3);
        hd[0] = h0; hd[1] = h1; hd[2] = h2; hd[3] = h3;
        drive_heads();
    endtask

    // One clock: inputs already driven after a negedge; returns at the next negedge.
    task automatic cycle();
        int w;
        #1;
        w = model_win();
        chk("pop", int'(pop), (w >= 0) ? (1 << w) : 0);
        chk("idle", int'(idle), (empty == 4'hF) ? 1 : 0);
        pop_s = int'(pop);
        @(posedge clk);
        if (!reset_L) begin
            model_reset();
        end else if (w >= 0) begin
            m_push = 1 << ((hd[w] >> 4) & 3);
            m_data = hd[w];
            m_gid  = w;
            m_cnt  = (m_cnt + 1) % 256;
            m_last = w;
        end else begin
            m_push = 0;
        end
        #1;
        chk("push", int'(push), m_push);
        chk("data_out", int'(data_out), m_data);
        chk("grant_id", int'(grant_id), m_gid);
        chk("fwd_count", int'(fwd_count), m_cnt);
        @(negedge clk);
    endtask

    initial begin
        int rr_pops [5];
        int ab_pops [4];
        rr_pops = '{1, 2, 4, 8, 1};
        ab_pops = '{8, 1, 2, 4};

        reset_L = 1'b1; enable = 1'b0; rr_mode = 1'b1;
        empty = 4'hF; almost_full = 4'h0;
        set_heads(0, 0, 0, 0);
        #1 reset_L = 1'b0;
        #1;
        chk("rst_push", int'(push), 0);
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_grant_id", int'(grant_id), 0);
        chk("rst_fwd_count", int'(fwd_count), 0);
        chk("rst_idle", int'(idle), 1);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_L = 1'b1;

        // Round-robin over four channels, all to destination 0.
        enable = 1'b1; rr_mode = 1'b1; empty = 4'h0; almost_full = 4'h0;
        set_heads(6'h01, 6'h02, 6'h03, 6'h04);
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("rr_pop_seq", pop_s, rr_pops[k]);
            chk("rr_push", int'(push), 1);
            if (k == 3) chk("rr_fwd4", int'(fwd_count), 4);
        end

        // Strict priority holds channel 0 until it empties.
        rr_mode = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("sp_pop_ch0", pop_s, 1);
        end
        empty = 4'b0001;
        cycle();
        chk("sp_pop_ch1", pop_s, 2);

        // Destination 2 almost full: only channel 2 (dest 1) moves.
        rr_mode = 1'b1; empty = 4'h0; almost_full = 4'b0100;
        set_heads(6'h21, 6'h22, 6'h13, 6'h24);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("af_pop_ch2", pop_s, 4);
            chk("af_push_dest1", int'(push), 2);
        end
        almost_full = 4'h0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("af_resume", pop_s, ab_pops[k]);
        end

        // Enable drop: in-flight push completes, then nothing.
        set_heads(6'h05, 6'h06, 6'h07, 6'h08);
        cycle();
        enable = 1'b0;
        chk("en_inflight_push", int'(push), 1);
        cycle();
        chk("en_off_pop", pop_s, 0);
        chk("en_off_push", int'(push), 0);
        cycle();
        chk("en_off_push2", int'(push), 0);
        enable = 1'b1;
        cycle();
        chk("en_back_pop", (pop_s != 0) ? 1 : 0, 1);

        // Asynchronous reset mid-stream.
        cycle();
        #2 reset_L = 1'b0;
        #1;
        chk("arst_push", int'(push), 0);
        chk("arst_data_out", int'(data_out), 0);
        chk("arst_fwd_count", int'(fwd_count), 0);
        model_reset();
        @(negedge clk);
        cycle();
        reset_L = 1'b1;
        cycle();
        chk("arst_first_ch0", pop_s, 1);

        // Counter wrap 255 -> 0.
        for (int k = 0; k < 300 && m_cnt != 255; k++) cycle();
        chk("cnt_255", int'(fwd_count), 255);
        cycle();
        chk("cnt_wrap", int'(fwd_count), 0);

        // Random traffic.
        for (int k = 0; k < 800; k++) begin
            for (int i = 0; i < NUM_CH; i++) hd[i] = int'($urandom_range(63, 0));
            drive_heads();
            empty       = 4'($urandom_range(15, 0) & $urandom_range(15, 0));
            almost_full = ($urandom_range(3, 0) == 0) ? 4'($urandom_range(15, 0)) : 4'h0;
            enable      = ($urandom_range(9, 0) != 0);
            if ($urandom_range(7, 0) == 0) rr_mode = ~rr_mode;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=%0t required=finish", $time);
        $fatal(1, "timeout");
    end

endmodule
